wbm_bridge: RTL and testbench



---
 rtl/mcu_pkg.sv | 10 +
 rtl/wbm_timeout_ctr.sv | 37 +++
 rtl/wbm_bridge.sv | 107 ++++++++++
 tb/tb_wbm_bridge.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// mcu_pkg: shared Wishbone widths, bridge FSM encoding and response codes
package mcu_pkg;
  localparam int WB_DW = 32;
  localparam int WB_AW = 32;
  localparam int WB_SELW = 4;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic RSP_ERR_TIMEOUT = 1'b1;
endpackage

// File: rtl/wbm_timeout_ctr.sv
// wbm_timeout_ctr: saturating ack-wait counter plus optional retry attempt counter
//   clk, rst_n : clock, async active-low reset
//   clr        : new command accepted; clears cycle and attempt counts
//   en         : one more cycle waited without ack
//   restart    : retry starting; clears cycle count, bumps attempts
//   expired    : TIMEOUT-1 cycles already waited
//   retry_ok   : another attempt is allowed (only with WBM_RETRY_EN defined)
module wbm_timeout_ctr #(
  parameter int TIMEOUT = 16,
  parameter int RETRIES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic restart,
  output logic expired,
  output logic retry_ok
);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr || restart) cnt <= '0;
    else if (en && cnt != 8'hFF) cnt <= cnt + 8'd1;
  assign expired = cnt == 8'(TIMEOUT - 1);
`ifdef WBM_RETRY_EN
  logic [2:0] attempts;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) attempts <= '0;
    else if (clr) attempts <= '0;
    else if (restart) attempts <= attempts + 3'd1;
  assign retry_ok = attempts < 3'(RETRIES);
`else
  // no retries in this build: RETRIES is never negative, so this is constant 0
  assign retry_ok = RETRIES < 0;
`endif
endmodule

// File: rtl/wbm_bridge.sv
// wbm_bridge: Wishbone B3 classic initiator, one bus cycle per valid/ready command, with ack timeout
//   wb_clk_i, wb_rst_ni : clock, async active-low reset
//   cmd_*               : command channel (we/adr/dat/sel), accepted on valid & ready
//   rsp_*               : response channel (read data, timeout error)
//   wbm_*               : Wishbone master signals
//   busy_o              : any state other than IDLE
//   Optional: define WBM_RETRY_EN to retry a timed-out cycle up to RETRIES times.
module wbm_bridge
  import mcu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int RETRIES = 1
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_we_i,
  input  logic [WB_AW-1:0]   cmd_adr_i,
  input  logic [WB_DW-1:0]   cmd_dat_i,
  input  logic [WB_SELW-1:0] cmd_sel_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [WB_DW-1:0]   rsp_dat_o,
  output logic               rsp_err_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [WB_SELW-1:0] wbm_sel_o,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  input  logic               wbm_ack_i,
  input  logic [WB_DW-1:0]   wbm_dat_i,
  output logic               busy_o
);
  logic [1:0] state;
  logic gap, waiting, expired, retry_ok, timeout;
  assign cmd_ready_o = state == IDLE;
  // gap is the one idle cycle between retry attempts; ack is not looked at then
  assign waiting = state == BUS && !gap;
  assign timeout = waiting && !wbm_ack_i && expired;
  wbm_timeout_ctr #(.TIMEOUT(TIMEOUT), .RETRIES(RETRIES)) u_ctr (
    .clk(wb_clk_i),
    .rst_n(wb_rst_ni),
    .clr(cmd_valid_i && cmd_ready_o),
    .en(waiting && !wbm_ack_i),
    .restart(timeout && retry_ok),
    .expired(expired),
    .retry_ok(retry_ok)
  );
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      state <= IDLE;
      gap <= 1'b0;
      busy_o <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o <= '0;
      rsp_err_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid_i) begin
          wbm_we_o <= cmd_we_i;
          wbm_adr_o <= cmd_adr_i;
          wbm_dat_o <= cmd_dat_i;
          wbm_sel_o <= cmd_sel_i;
          wbm_cyc_o <= 1'b1;
          wbm_stb_o <= 1'b1;
          busy_o <= 1'b1;
          state <= BUS;
        end
        BUS: if (gap) begin
          gap <= 1'b0;
          wbm_cyc_o <= 1'b1;
          wbm_stb_o <= 1'b1;
        end else if (wbm_ack_i) begin
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          rsp_dat_o <= wbm_we_o ? '0 : wbm_dat_i;
          rsp_err_o <= 1'b0;
          rsp_valid_o <= 1'b1;
          state <= RESP;
        end else if (timeout) begin
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          if (retry_ok) gap <= 1'b1;
          else begin
            rsp_dat_o <= '0;
            rsp_err_o <= RSP_ERR_TIMEOUT;
            rsp_valid_o <= 1'b1;
            state <= RESP;
          end
        end
        RESP: if (rsp_ready_i) begin
          rsp_valid_o <= 1'b0;
          busy_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_wbm_bridge.sv
// tb_wbm_bridge: randomized self-checking bench for wbm_bridge against a transaction-timing model
module tb_wbm_bridge;
  localparam int TO = 16;
  localparam int RT = 1;
`ifdef WBM_RETRY_EN
  localparam int TRIES = RT + 1;
  localparam int HUNG_CYC = 32;
`else
  localparam int TRIES = 1;
  localparam int HUNG_CYC = 16;
`endif
  logic wb_clk_i = 1'b0, wb_rst_ni = 1'b0;
  logic cmd_valid_i = 1'b0, cmd_we_i = 1'b0, rsp_ready_i = 1'b0, wbm_ack_i = 1'b0;
  logic [31:0] cmd_adr_i = '0, cmd_dat_i = '0, wbm_dat_i = '0;
  logic [3:0] cmd_sel_i = '0;
  logic cmd_ready_o, rsp_valid_o, rsp_err_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o;
  logic [31:0] rsp_dat_o, wbm_adr_o, wbm_dat_o;
  logic [3:0] wbm_sel_o;
  wbm_bridge #(.TIMEOUT(TO), .RETRIES(RT)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
    .busy_o(busy_o)
  );
  always #5 wb_clk_i = ~wb_clk_i;
  logic e_ready = 1'b1, e_busy = 1'b0, e_cyc = 1'b0, e_stb = 1'b0, e_we = 1'b0, e_valid = 1'b0, e_err = 1'b0;
  logic [31:0] e_adr = '0, e_dat = '0, e_rdat = '0, last_rdat = '0;
  logic [3:0] e_sel = '0;
  logic last_err = 1'b0;
  int nassert = 0, nfail = 0, obs_cyc = 0, first_v = 0, nidx = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nassert++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge wb_clk_i) begin
    check("cmd_ready", 32'(cmd_ready_o), 32'(e_ready));
    check("busy", 32'(busy_o), 32'(e_busy));
    check("cyc", 32'(wbm_cyc_o), 32'(e_cyc));
    check("stb", 32'(wbm_stb_o), 32'(e_stb));
    check("we", 32'(wbm_we_o), 32'(e_we));
    check("adr", wbm_adr_o, e_adr);
    check("wdat", wbm_dat_o, e_dat);
    check("sel", 32'(wbm_sel_o), 32'(e_sel));
    check("rsp_valid", 32'(rsp_valid_o), 32'(e_valid));
    if (e_valid) begin
      check("rsp_dat", rsp_dat_o, e_rdat);
      check("rsp_err", 32'(rsp_err_o), 32'(e_err));
    end
    nidx++;
    if (wbm_cyc_o) obs_cyc++;
    if (rsp_valid_o && first_v == 0) begin
      first_v = nidx;
      last_rdat = rsp_dat_o;
      last_err = rsp_err_o;
    end
  end
  task automatic step;
    @(posedge wb_clk_i);
    #1;
  endtask
  task automatic noise;
    wbm_ack_i = 1'($urandom);
    wbm_dat_i = $urandom;
  endtask
  task automatic accept(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
    noise();
    step();
    nidx = 0; first_v = 0; obs_cyc = 0;
    cmd_valid_i = 1'($urandom); cmd_we_i = 1'($urandom);
    cmd_adr_i = $urandom; cmd_dat_i = $urandom; cmd_sel_i = 4'($urandom);
    e_ready = 1'b0; e_busy = 1'b1; e_cyc = 1'b1; e_stb = 1'b1;
    e_we = we; e_adr = adr; e_dat = dat; e_sel = sel;
  endtask
  // slave acks d cycles after stb of each attempt rises; d >= TO means it never acks in time
  task automatic finish_bus(input logic we, input int d, input logic [31:0] rd);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < TRIES && !ok; t++) begin
      for (int j = 1; j <= TO && !ok; j++) begin
        wbm_ack_i = j == d + 1;
        wbm_dat_i = (j == d + 1) ? rd : $urandom;
        step();
        if (j == d + 1) ok = 1'b1;
      end
      e_cyc = 1'b0; e_stb = 1'b0;
      if (!ok && t < TRIES - 1) begin
        wbm_ack_i = 1'b0;
        step();
        e_cyc = 1'b1; e_stb = 1'b1;
      end
    end
    e_valid = 1'b1; e_err = !ok; e_rdat = (ok && !we) ? rd : 32'h0;
  endtask
  task automatic drain(input int hold);
    for (int k = 0; k < hold; k++) begin
      rsp_ready_i = 1'b0;
      cmd_valid_i = 1'b1;
      noise();
      step();
    end
    rsp_ready_i = 1'b1;
    noise();
    step();
    rsp_ready_i = 1'b0; cmd_valid_i = 1'b0; wbm_ack_i = 1'b0;
    e_valid = 1'b0; e_ready = 1'b1; e_busy = 1'b0;
  endtask
  task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                     input int d, input logic [31:0] rd, input int hold);
    accept(we, adr, dat, sel);
    finish_bus(we, d, rd);
    drain(hold);
  endtask
  initial begin
    int r, d;
    repeat (3) step();
    check("rst_ready", 32'(cmd_ready_o), 32'd1);
    check("rst_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_rdat", rsp_dat_o, 32'd0);
    check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    wb_rst_ni = 1'b1;
    step();
    txn(1'b1, 32'h3000_0004, 32'hA5A5_5A5A, 4'hF, 3, 32'h0, 1);
    check("t1_cyc_len", 32'(obs_cyc), 32'd4);
    check("t1_err", 32'(last_err), 32'd0);
    check("t1_rdat", last_rdat, 32'd0);
    txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 0, 32'h1234_5678, 0);
    check("t2_latency", 32'(first_v), 32'd2);
    check("t2_rdat", last_rdat, 32'h1234_5678);
    txn(1'b0, 32'h3000_0020, 32'h0, 4'h3, 1000, 32'h0000_DEAD, 0);
    check("t3_cyc_len", 32'(obs_cyc), 32'(HUNG_CYC));
    check("t3_err", 32'(last_err), 32'd1);
    check("t3_rdat", last_rdat, 32'd0);
    txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, TO - 1, 32'hCAFE_F00D, 0);
    check("t4_cyc_len", 32'(obs_cyc), 32'd16);
    check("t4_err", 32'(last_err), 32'd0);
    check("t4_rdat", last_rdat, 32'hCAFE_F00D);
    txn(1'b1, 32'h3000_0040, 32'h0BAD_BEEF, 4'h6, 2, 32'h0, 10);
    txn(1'b0, 32'h3000_0044, 32'h0, 4'hF, 1, 32'h7777_1111, 0);
    check("t5_latency", 32'(first_v), 32'd3);
    accept(1'b1, 32'h3000_0100, 32'h55, 4'h1);
    wbm_ack_i = 1'b0;
    step();
    step();
    #2;
    check("pre_rst_cyc", 32'(wbm_cyc_o), 32'd1);
    wb_rst_ni = 1'b0;
    cmd_valid_i = 1'b0;
    e_ready = 1'b1; e_busy = 1'b0; e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
    e_adr = '0; e_dat = '0; e_sel = '0; e_valid = 1'b0;
    #1;
    check("async_rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("async_rst_stb", 32'(wbm_stb_o), 32'd0);
    @(posedge wb_clk_i);
    #1 wb_rst_ni = 1'b1;
    repeat (3) begin
      noise();
      step();
    end
    wbm_ack_i = 1'b0;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      d = r < 6 ? $urandom_range(0, 5) : r < 8 ? $urandom_range(TO - 2, TO) : 1000;
      txn(1'($urandom), $urandom, $urandom, 4'($urandom), d, $urandom, $urandom_range(0, 4));
      repeat ($urandom_range(0, 2)) begin
        noise();
        step();
      end
      wbm_ack_i = 1'b0;
    end
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
